// File: rtl/cpu_controller_pkg.sv
// Shared definitions for the instruction controller.
// Holds the FSM state encoding, the instruction-field layout of the IR,
// the opcode/op values the decoder recognises, the writeback-select and
// register-select encodings, and the per-state control bundle.
// The helper functions map an (opcode, op) pair to the next state and
// build the registered control word for the state being entered.
package cpu_controller_pkg;

    typedef enum logic [2:0] {
        S_WAIT   = 3'd0,
        S_DECODE = 3'd1,
        S_WR_IMM = 3'd2,
        S_GET_A  = 3'd3,
        S_GET_B  = 3'd4,
        S_EXEC   = 3'd5,
        S_CMP    = 3'd6,
        S_WR_REG = 3'd7
    } state_t;

    // Which IR register field drives readnum/writenum.
    typedef enum logic [1:0] {
        NSEL_NONE = 2'b00,
        NSEL_RN   = 2'b01,
        NSEL_RD   = 2'b10,
        NSEL_RM   = 2'b11
    } nsel_t;

    // Writeback source select.
    typedef enum logic [1:0] {
        VSEL_C     = 2'b00,
        VSEL_PC    = 2'b01,
        VSEL_IMM8  = 2'b10,
        VSEL_MDATA = 2'b11
    } vsel_t;

    // Instruction register layout.
    localparam int IR_WIDTH    = 16;
    localparam int IR_OPC_LSB  = 13;
    localparam int IR_OP_LSB   = 11;
    localparam int IR_RN_LSB   = 8;
    localparam int IR_RD_LSB   = 5;
    localparam int IR_SH_LSB   = 3;
    localparam int IR_RM_LSB   = 0;
    localparam int IR_IMM8_MSB = 7;
    localparam int IR_IMM5_MSB = 4;

    // Opcode and op values.
    localparam logic [2:0] OPC_MOV    = 3'b110;
    localparam logic [2:0] OPC_ALU    = 3'b101;
    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_AND     = 2'b10;
    localparam logic [1:0] OP_MVN     = 2'b11;

    // ALU codes used directly by the controller.
    localparam logic [1:0] ALU_PASS = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;

    // Registered control word; one field per datapath strobe/select.
    typedef struct packed {
        logic       w;
        logic       illegal;
        logic       write;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       asel;
        vsel_t      vsel;
        logic [1:0] aluop;
        logic [1:0] shift;
        nsel_t      nsel;
    } ctrl_t;

    // State reached from DECODE; S_WAIT means the encoding is undefined.
    function automatic state_t decode_target(input logic [2:0] opc, input logic [1:0] op);
        state_t t;
        t = S_WAIT;
        if (opc == OPC_MOV) begin
            if (op == OP_MOV_IMM) begin
                t = S_WR_IMM;
            end else if (op == OP_MOV_REG) begin
                t = S_GET_B;
            end
        end else if (opc == OPC_ALU) begin
            case (op)
                OP_ADD, OP_CMP, OP_AND: t = S_GET_A;
                OP_MVN:                 t = S_GET_B;
                default:                t = S_WAIT;
            endcase
        end
        return t;
    endfunction

    // State reached from GET_B: compare skips the C/writeback path.
    function automatic state_t get_b_target(input logic [2:0] opc, input logic [1:0] op);
        return ((opc == OPC_ALU) && (op == OP_CMP)) ? S_CMP : S_EXEC;
    endfunction

    // Control word presented while in state st.
    function automatic ctrl_t ctrl_for(input state_t st, input logic [2:0] opc,
                                       input logic [1:0] op, input logic [1:0] sh);
        ctrl_t c;
        c      = '0;
        c.vsel = VSEL_C;
        c.nsel = NSEL_NONE;
        case (st)
            S_WAIT:   c.w = 1'b1;
            S_DECODE: c.illegal = (decode_target(opc, op) == S_WAIT);
            S_WR_IMM: begin
                c.nsel  = NSEL_RN;
                c.vsel  = VSEL_IMM8;
                c.write = 1'b1;
            end
            S_GET_A: begin
                c.nsel  = NSEL_RN;
                c.loada = 1'b1;
            end
            S_GET_B: begin
                c.nsel  = NSEL_RM;
                c.loadb = 1'b1;
            end
            S_EXEC: begin
                c.loadc = 1'b1;
                c.shift = sh;
                c.aluop = (opc == OPC_ALU) ? op : ALU_PASS;
                // MOV passes the shifted B operand through with A forced to 0.
                c.asel  = (opc == OPC_MOV);
            end
            S_CMP: begin
                c.loads = 1'b1;
                c.shift = sh;
                c.aluop = ALU_SUB;
            end
            S_WR_REG: begin
                c.nsel  = NSEL_RD;
                c.vsel  = VSEL_C;
                c.write = 1'b1;
            end
            default: c.w = 1'b1;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/cpu_controller_if.sv
// Bundle between the instruction source / datapath and the controller.
// master: drives the instruction word (in), load and s; observes the rest.
// slave : the controller; drives w, illegal, register indices, datapath
//         strobes/selects and the sign-extended immediates.
interface cpu_controller_if #(
    parameter int data_width = 16
);
    logic [15:0]           in;
    logic                  load;
    logic                  s;
    logic                  w;
    logic                  illegal;
    logic [2:0]            readnum;
    logic [2:0]            writenum;
    logic                  write;
    logic                  loada;
    logic                  loadb;
    logic                  loadc;
    logic                  loads;
    logic                  asel;
    logic                  bsel;
    logic [1:0]            vsel;
    logic [1:0]            ALUop;
    logic [1:0]            shift;
    logic [data_width-1:0] sximm8;
    logic [data_width-1:0] sximm5;

    modport master (
        output in, load, s,
        input  w, illegal, readnum, writenum, write, loada, loadb, loadc, loads,
               asel, bsel, vsel, ALUop, shift, sximm8, sximm5
    );

    modport slave (
        input  in, load, s,
        output w, illegal, readnum, writenum, write, loada, loadb, loadc, loads,
               asel, bsel, vsel, ALUop, shift, sximm8, sximm5
    );
endinterface

// File: rtl/cpu_controller_instr_dec.sv
// Instruction register and field decoder.
// Ports:
//   clk, reset      - clock and synchronous active-high reset (clears IR)
//   in, capture     - IR loads `in` on a clock edge where capture is high
//   nsel            - selects Rn/Rd/Rm (or zero) onto readnum/writenum
//   opcode/op/shift - fields of the current IR
//   opcode_next/op_next - fields of the value IR will hold after this edge,
//                     so a same-cycle load+start decodes the new word
//   sximm8, sximm5  - sign-extended IR[7:0] / IR[4:0], combinational
module cpu_controller_instr_dec
    import cpu_controller_pkg::*;
#(
    parameter int data_width = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [IR_WIDTH-1:0]   in,
    input  logic                  capture,
    input  nsel_t                 nsel,
    output logic [2:0]            opcode,
    output logic [1:0]            op,
    output logic [1:0]            shift,
    output logic [2:0]            opcode_next,
    output logic [1:0]            op_next,
    output logic [2:0]            readnum,
    output logic [2:0]            writenum,
    output logic [data_width-1:0] sximm8,
    output logic [data_width-1:0] sximm5
);
    logic [IR_WIDTH-1:0] ir_reg;
    logic [IR_WIDTH-1:0] ir_next;
    logic [2:0]          num;

    always_comb begin
        ir_next = capture ? in : ir_reg;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ir_reg <= '0;
        end else begin
            ir_reg <= ir_next;
        end
    end

    assign opcode      = ir_reg[IR_OPC_LSB +: 3];
    assign op          = ir_reg[IR_OP_LSB +: 2];
    assign shift       = ir_reg[IR_SH_LSB +: 2];
    assign opcode_next = ir_next[IR_OPC_LSB +: 3];
    assign op_next     = ir_next[IR_OP_LSB +: 2];

    always_comb begin
        num = 3'd0;
        case (nsel)
            NSEL_RN: num = ir_reg[IR_RN_LSB +: 3];
            NSEL_RD: num = ir_reg[IR_RD_LSB +: 3];
            NSEL_RM: num = ir_reg[IR_RM_LSB +: 3];
            default: num = 3'd0;
        endcase
    end

    // Read and write ports always address the same register.
    assign readnum  = num;
    assign writenum = num;

    genvar gi;
    generate
        for (gi = 0; gi < data_width; gi++) begin : g_sext
            if (gi <= IR_IMM8_MSB) begin : g_imm8_lo
                assign sximm8[gi] = ir_reg[gi];
            end else begin : g_imm8_hi
                assign sximm8[gi] = ir_reg[IR_IMM8_MSB];
            end
            if (gi <= IR_IMM5_MSB) begin : g_imm5_lo
                assign sximm5[gi] = ir_reg[gi];
            end else begin : g_imm5_hi
                assign sximm5[gi] = ir_reg[IR_IMM5_MSB];
            end
        end
    endgenerate

endmodule

// File: rtl/cpu_controller.sv
// Multi-cycle instruction controller.
// Ports:
//   clk   - sole clock, rising edge
//   reset - synchronous active-high; returns to WAIT, clears IR, w=1
//   bus   - cpu_controller_if.slave: in/load/s from the instruction source,
//           w/illegal status, readnum/writenum, datapath strobes
//           (write, loada, loadb, loadc, loads), selects (asel, bsel, vsel),
//           ALUop, shift and sign-extended immediates sximm8/sximm5.
// All control outputs come straight from registers: on every transition the
// control word for the state being entered is registered with the state.
module cpu_controller #(
    parameter int data_width = 16
) (
    input  logic            clk,
    input  logic            reset,
    cpu_controller_if.slave bus
);
    import cpu_controller_pkg::*;

    state_t     state_reg;
    ctrl_t      ctrl_reg;
    logic [2:0] opcode;
    logic [2:0] opcode_next;
    logic [1:0] op;
    logic [1:0] op_next;
    logic [1:0] shift_f;
    logic       capture;

    // IR is only writable while idle.
    assign capture = bus.load && (state_reg == S_WAIT);

    cpu_controller_instr_dec #(
        .data_width (data_width)
    ) u_instr_dec (
        .clk         (clk),
        .reset       (reset),
        .in          (bus.in),
        .capture     (capture),
        .nsel        (ctrl_reg.nsel),
        .opcode      (opcode),
        .op          (op),
        .shift       (shift_f),
        .opcode_next (opcode_next),
        .op_next     (op_next),
        .readnum     (bus.readnum),
        .writenum    (bus.writenum),
        .sximm8      (bus.sximm8),
        .sximm5      (bus.sximm5)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_WAIT;
            ctrl_reg  <= ctrl_for(S_WAIT, 3'b000, 2'b00, 2'b00);
        end else begin
            unique case (state_reg)
                S_WAIT: begin
                    if (bus.s) begin
                        // Decode the word IR is capturing this edge, so a
                        // simultaneous load+s flags illegality correctly.
                        state_reg <= S_DECODE;
                        ctrl_reg  <= ctrl_for(S_DECODE, opcode_next, op_next, shift_f);
                    end
                end
                S_DECODE: begin
                    state_reg <= decode_target(opcode, op);
                    ctrl_reg  <= ctrl_for(decode_target(opcode, op), opcode, op, shift_f);
                end
                S_GET_A: begin
                    state_reg <= S_GET_B;
                    ctrl_reg  <= ctrl_for(S_GET_B, opcode, op, shift_f);
                end
                S_GET_B: begin
                    state_reg <= get_b_target(opcode, op);
                    ctrl_reg  <= ctrl_for(get_b_target(opcode, op), opcode, op, shift_f);
                end
                S_EXEC: begin
                    state_reg <= S_WR_REG;
                    ctrl_reg  <= ctrl_for(S_WR_REG, opcode, op, shift_f);
                end
                S_WR_IMM, S_CMP, S_WR_REG: begin
                    state_reg <= S_WAIT;
                    ctrl_reg  <= ctrl_for(S_WAIT, opcode, op, shift_f);
                end
            endcase
        end
    end

    assign bus.w       = ctrl_reg.w;
    assign bus.illegal = ctrl_reg.illegal;
    assign bus.write   = ctrl_reg.write;
    assign bus.loada   = ctrl_reg.loada;
    assign bus.loadb   = ctrl_reg.loadb;
    assign bus.loadc   = ctrl_reg.loadc;
    assign bus.loads   = ctrl_reg.loads;
    assign bus.asel    = ctrl_reg.asel;
    assign bus.bsel    = 1'b0;
    assign bus.vsel    = ctrl_reg.vsel;
    assign bus.ALUop   = ctrl_reg.aluop;
    assign bus.shift   = ctrl_reg.shift;

endmodule

// File: tb/tb_cpu_controller.sv
`timescale 1ns/1ps
module tb_cpu_controller;

    localparam int DW = 16;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    cpu_controller_if #(.data_width(DW)) bus ();

    cpu_controller #(.data_width(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Expected datapath transaction: one record per cycle with a strobe or illegal.
    typedef struct packed {
        logic        illegal;
        logic        write;
        logic        loada;
        logic        loadb;
        logic        loadc;
        logic        loads;
        logic        asel;
        logic [1:0]  vsel;
        logic        alu_v;
        logic [1:0]  aluop;
        logic [1:0]  shift;
        logic        num_v;
        logic [2:0]  num;
        logic [15:0] sx8;
        logic [15:0] sx5;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    exp_t mon_a;
    logic mon_ok;
    int   checks = 0;
    int   passes = 0;
    int   txn    = 0;

    function automatic exp_t e_base(input logic [15:0] sx8, input logic [15:0] sx5);
        exp_t e;
        e     = '0;
        e.sx8 = sx8;
        e.sx5 = sx5;
        return e;
    endfunction

    function automatic exp_t e_wr_imm(input logic [2:0] n, input logic [15:0] sx8, input logic [15:0] sx5);
        exp_t e;
        e = e_base(sx8, sx5);
        e.write = 1'b1; e.vsel = 2'b10; e.num_v = 1'b1; e.num = n;
        return e;
    endfunction

    function automatic exp_t e_get_a(input logic [2:0] n, input logic [15:0] sx8, input logic [15:0] sx5);
        exp_t e;
        e = e_base(sx8, sx5);
        e.loada = 1'b1; e.num_v = 1'b1; e.num = n;
        return e;
    endfunction

    function automatic exp_t e_get_b(input logic [2:0] n, input logic [15:0] sx8, input logic [15:0] sx5);
        exp_t e;
        e = e_base(sx8, sx5);
        e.loadb = 1'b1; e.num_v = 1'b1; e.num = n;
        return e;
    endfunction

    function automatic exp_t e_exec(input logic [1:0] alu, input logic [1:0] sh, input logic as,
                                    input logic [15:0] sx8, input logic [15:0] sx5);
        exp_t e;
        e = e_base(sx8, sx5);
        e.loadc = 1'b1; e.alu_v = 1'b1; e.aluop = alu; e.shift = sh; e.asel = as;
        return e;
    endfunction

    function automatic exp_t e_cmp(input logic [1:0] sh, input logic [15:0] sx8, input logic [15:0] sx5);
        exp_t e;
        e = e_base(sx8, sx5);
        e.loads = 1'b1; e.alu_v = 1'b1; e.aluop = 2'b01; e.shift = sh;
        return e;
    endfunction

    function automatic exp_t e_wr_reg(input logic [2:0] n, input logic [15:0] sx8, input logic [15:0] sx5);
        exp_t e;
        e = e_base(sx8, sx5);
        e.write = 1'b1; e.vsel = 2'b00; e.num_v = 1'b1; e.num = n;
        return e;
    endfunction

    function automatic exp_t e_illegal(input logic [15:0] sx8, input logic [15:0] sx5);
        exp_t e;
        e = e_base(sx8, sx5);
        e.illegal = 1'b1;
        return e;
    endfunction

    // Monitor: any strobe or illegal pulse is a transaction to match against the queue.
    always @(negedge clk) begin
        if (bus.write || bus.loada || bus.loadb || bus.loadc || bus.loads || bus.illegal) begin
            checks++;
            txn++;
            mon_a         = '0;
            mon_a.illegal = bus.illegal;
            mon_a.write   = bus.write;
            mon_a.loada   = bus.loada;
            mon_a.loadb   = bus.loadb;
            mon_a.loadc   = bus.loadc;
            mon_a.loads   = bus.loads;
            mon_a.asel    = bus.asel;
            mon_a.vsel    = bus.vsel;
            mon_a.alu_v   = 1'b1;
            mon_a.aluop   = bus.ALUop;
            mon_a.shift   = bus.shift;
            mon_a.num_v   = 1'b1;
            mon_a.num     = bus.writenum;
            mon_a.sx8     = bus.sximm8;
            mon_a.sx5     = bus.sximm5;
            if (exp_q.size() == 0) begin
                $display("FAIL txn_%0d unexpected: actual=%h readnum=%0d required=no strobe", txn, mon_a, bus.readnum);
            end else begin
                mon_e  = exp_q.pop_front();
                mon_ok = (mon_a.illegal == mon_e.illegal) && (mon_a.write == mon_e.write)
                      && (mon_a.loada == mon_e.loada) && (mon_a.loadb == mon_e.loadb)
                      && (mon_a.loadc == mon_e.loadc) && (mon_a.loads == mon_e.loads)
                      && (mon_a.asel == mon_e.asel) && (mon_a.vsel == mon_e.vsel)
                      && (bus.bsel == 1'b0)
                      && (!mon_e.alu_v || ((mon_a.aluop == mon_e.aluop) && (mon_a.shift == mon_e.shift)))
                      && (!mon_e.num_v || ((bus.writenum == mon_e.num) && (bus.readnum == mon_e.num)))
                      && (mon_a.sx8 == mon_e.sx8) && (mon_a.sx5 == mon_e.sx5);
                if (mon_ok) begin
                    passes++;
                    $display("txn %0d ok: ill=%b wr=%b la=%b lb=%b lc=%b ls=%b asel=%b vsel=%b alu=%b sh=%b rn=%0d wn=%0d sx8=%h sx5=%h",
                             txn, bus.illegal, bus.write, bus.loada, bus.loadb, bus.loadc, bus.loads, bus.asel,
                             bus.vsel, bus.ALUop, bus.shift, bus.readnum, bus.writenum, bus.sximm8, bus.sximm5);
                end else begin
                    $display("FAIL txn_%0d: actual=%h readnum=%0d bsel=%b required=%h", txn, mon_a, bus.readnum, bus.bsel, mon_e);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) begin
            passes++;
        end else begin
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [19:0] ctl_vec();
        return {bus.illegal, bus.write, bus.loada, bus.loadb, bus.loadc, bus.loads, bus.asel, bus.bsel,
                bus.vsel, bus.ALUop, bus.shift, bus.readnum, bus.writenum};
    endfunction

    // Issue one instruction (load then s, or both together) and measure edges to w=1.
    task automatic run_instr(input logic [15:0] ir, input bit together, input int lat, input string name);
        int n;
        bus.in   = ir;
        bus.load = 1'b1;
        bus.s    = together;
        @(posedge clk); #1;
        if (!together) begin
            bus.load = 1'b0;
            bus.s    = 1'b1;
            @(posedge clk); #1;
        end
        bus.load = 1'b0;
        bus.s    = 1'b0;
        n = 1;
        while (!bus.w && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_latency"}, n, lat);
    endtask

    // ADD with load held during the instruction and s pulsed during EXEC.
    task automatic run_add_disturbed();
        int n;
        bus.in   = 16'hA049;
        bus.load = 1'b1;
        bus.s    = 1'b1;
        @(posedge clk); #1;
        n = 1;
        forever begin
            bus.in   = 16'hD0FF;
            bus.load = (n <= 4);
            bus.s    = (n == 4);
            if (bus.w || n >= 20) break;
            @(posedge clk); #1;
            n++;
        end
        bus.load = 1'b0;
        bus.s    = 1'b0;
        check("disturbed_latency", n, 6);
        check("disturbed_ir_kept", bus.sximm8, 16'h0049);
        @(posedge clk); #1;
        check("disturbed_idle", bus.w, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        bus.in   = 16'h0000;
        bus.load = 1'b0;
        bus.s    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_w", bus.w, 1'b1);
        check("reset_ctl", ctl_vec(), 20'h0);
        check("reset_sximm", {bus.sximm8, bus.sximm5}, 32'h0);
        reset = 1'b0;
        @(posedge clk); #1;

        // MOV R0,#7
        exp_q.push_back(e_wr_imm(3'd0, 16'h0007, 16'h0007));
        run_instr(16'hD007, 1'b0, 3, "mov_imm");

        // MOV R3,#-1 with load and s together
        exp_q.push_back(e_wr_imm(3'd3, 16'hFFFF, 16'hFFFF));
        run_instr(16'hD3FF, 1'b1, 3, "mov_imm_neg");

        // ADD R2,R0,R1 LSL#1
        exp_q.push_back(e_get_a(3'd0, 16'h0049, 16'h0009));
        exp_q.push_back(e_get_b(3'd1, 16'h0049, 16'h0009));
        exp_q.push_back(e_exec(2'b00, 2'b01, 1'b0, 16'h0049, 16'h0009));
        exp_q.push_back(e_wr_reg(3'd2, 16'h0049, 16'h0009));
        run_instr(16'hA049, 1'b0, 6, "add");

        // CMP R0,R1
        exp_q.push_back(e_get_a(3'd0, 16'h0001, 16'h0001));
        exp_q.push_back(e_get_b(3'd1, 16'h0001, 16'h0001));
        exp_q.push_back(e_cmp(2'b00, 16'h0001, 16'h0001));
        run_instr(16'hA801, 1'b0, 5, "cmp");

        // Undefined opcode 111
        exp_q.push_back(e_illegal(16'h0000, 16'h0000));
        run_instr(16'hE000, 1'b1, 2, "illegal");

        // MOV R5,R3 LSR#1
        exp_q.push_back(e_get_b(3'd3, 16'hFFB3, 16'hFFF3));
        exp_q.push_back(e_exec(2'b00, 2'b10, 1'b1, 16'hFFB3, 16'hFFF3));
        exp_q.push_back(e_wr_reg(3'd5, 16'hFFB3, 16'hFFF3));
        run_instr(16'hC0B3, 1'b1, 5, "mov_reg");

        // MVN R1,R6
        exp_q.push_back(e_get_b(3'd6, 16'h0026, 16'h0006));
        exp_q.push_back(e_exec(2'b11, 2'b00, 1'b0, 16'h0026, 16'h0006));
        exp_q.push_back(e_wr_reg(3'd1, 16'h0026, 16'h0006));
        run_instr(16'hB826, 1'b0, 5, "mvn");

        // AND R7,R4,R7
        exp_q.push_back(e_get_a(3'd4, 16'hFFE7, 16'h0007));
        exp_q.push_back(e_get_b(3'd7, 16'hFFE7, 16'h0007));
        exp_q.push_back(e_exec(2'b10, 2'b00, 1'b0, 16'hFFE7, 16'h0007));
        exp_q.push_back(e_wr_reg(3'd7, 16'hFFE7, 16'h0007));
        run_instr(16'hB4E7, 1'b1, 6, "and");

        // sximm5 negative, observed while idle after a plain load
        bus.in   = 16'hA01F;
        bus.load = 1'b1;
        @(posedge clk); #1;
        bus.load = 1'b0;
        check("sximm5_neg", bus.sximm5, 16'hFFFF);
        check("sximm8_pos", bus.sximm8, 16'h001F);
        check("load_idle_w", bus.w, 1'b1);

        // ADD R0,R0,R7 ASR
        exp_q.push_back(e_get_a(3'd0, 16'h001F, 16'hFFFF));
        exp_q.push_back(e_get_b(3'd7, 16'h001F, 16'hFFFF));
        exp_q.push_back(e_exec(2'b00, 2'b11, 1'b0, 16'h001F, 16'hFFFF));
        exp_q.push_back(e_wr_reg(3'd0, 16'h001F, 16'hFFFF));
        run_instr(16'hA01F, 1'b1, 6, "add_sh3");

        // load outside WAIT and s during EXEC must not disturb ADD
        exp_q.push_back(e_get_a(3'd0, 16'h0049, 16'h0009));
        exp_q.push_back(e_get_b(3'd1, 16'h0049, 16'h0009));
        exp_q.push_back(e_exec(2'b00, 2'b01, 1'b0, 16'h0049, 16'h0009));
        exp_q.push_back(e_wr_reg(3'd2, 16'h0049, 16'h0009));
        run_add_disturbed();

        // Reset during GET_B of ADD aborts the instruction
        exp_q.push_back(e_get_a(3'd0, 16'h0049, 16'h0009));
        exp_q.push_back(e_get_b(3'd1, 16'h0049, 16'h0009));
        bus.in   = 16'hA049;
        bus.load = 1'b1;
        bus.s    = 1'b1;
        @(posedge clk); #1;
        bus.load = 1'b0;
        bus.s    = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("abort_in_get_b", bus.loadb, 1'b1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_w", bus.w, 1'b1);
        check("abort_ctl", ctl_vec(), 20'h0);
        check("abort_ir", {bus.sximm8, bus.sximm5}, 32'h0);
        @(posedge clk); #1;
        check("abort_stays_idle", {bus.w, bus.write, bus.loads}, 3'b100);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drain", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/cpu_controller.md
CPU_CONTROLLER -- requirements
Module: cpu_controller

Interface
REQ-001 Parameter data_width, default 16, width of the sximm8/sximm5 outputs and of the datapath word.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in  input  16  instruction word to capture.
REQ-005 load  input  1  capture `in` into the instruction register (IR).
REQ-006 s  input  1  start execution of the IR contents.
REQ-007 w  output  1  high when idle and ready for a new instruction.
REQ-008 illegal  output  1  one-cycle pulse on an undefined opcode/op.
REQ-009 readnum, writenum  output  3 each  register index, driven together from the nsel-selected IR field.
REQ-010 write, loada, loadb, loadc, loads, asel, bsel  output  1 each  datapath strobes and selects.
REQ-011 vsel  output  2  writeback select: 00 C, 01 PC, 10 sximm8, 11 mdata.
REQ-012 ALUop, shift  output  2 each  ALU operation and shifter code.
REQ-013 sximm8, sximm5  output  data_width each  sign-extended IR[7:0] and IR[4:0].

Function
REQ-014 IR fields: opcode IR[15:13], op IR[12:11], Rn IR[10:8], Rd IR[7:5], shift IR[4:3], Rm IR[2:0].
REQ-015 IR captures `in` only when load=1 and w=1; load is ignored in every other state.
REQ-016 States: WAIT, DECODE, WR_IMM, GET_A, GET_B, EXEC, CMP, WR_REG.
REQ-017 WAIT: w=1; s=1 moves to DECODE; s is ignored in all other states.
REQ-018 With load and s both high in WAIT, the newly captured IR is executed.
REQ-019 DECODE, opcode 110/op 10 (MOV Rn,#imm8): next state WR_IMM.
REQ-020 DECODE, opcode 110/op 00 (MOV Rd,Rm{sh}): next state GET_B.
REQ-021 DECODE, opcode 101/op 00, 01, 10 (ADD, CMP, AND): next state GET_A.
REQ-022 DECODE, opcode 101/op 11 (MVN): next state GET_B.
REQ-023 DECODE, any other encoding: illegal=1 for one cycle, no strobes, next state WAIT.
REQ-024 WR_IMM: nsel=Rn, vsel=10, write=1; next state WAIT.
REQ-025 GET_A: nsel=Rn, loada=1; next state GET_B.
REQ-026 GET_B: nsel=Rm, loadb=1; next state CMP for CMP, EXEC otherwise.
REQ-027 EXEC: loadc=1, shift=IR[4:3]; ALUop=op for opcode 101, 00 for MOV; asel=1 for MOV, 0 otherwise; next state WR_REG.
REQ-028 CMP: loads=1, loadc=0, ALUop=01, asel=0, shift=IR[4:3]; next state WAIT.
REQ-029 WR_REG: nsel=Rd, vsel=00, write=1; next state WAIT.
REQ-030 Every strobe, asel, bsel and vsel is 0 in any state not listed above; bsel is always 0.
REQ-031 Latency from s sampled high back to w=1: MOV imm 3 cycles, CMP 5, MOV shift/MVN 5, ADD/AND 6.
REQ-032 sximm8 and sximm5 are combinational from IR and valid in all states.

Reset
REQ-033 At a reset edge: state=WAIT, IR=0, and every output is 0 except w=1.
REQ-034 Reset mid-instruction aborts the instruction; no write or loads strobe is issued on the following cycle.

Structure
REQ-035 A shared package holds: state enum, opcode/op constants, vsel encodings, IR field positions.
REQ-036 One sub-module, instr_dec: IR register, field extraction, nsel mux to readnum/writenum, sign extension.

Verification
REQ-037 MOV imm: load in=16'hD007, then pulse s -> WR_IMM has writenum=0, vsel=10, write=1, sximm8=16'h0007; w=1 3 cycles after s.
REQ-038 Sign extension: in=16'hD3FF -> sximm8=16'hFFFF, writenum=3; in=16'hA01F -> sximm5=16'hFFFF.
REQ-039 ADD: in=16'hA049 (ADD R2,R0,R1 LSL#1) -> loada with readnum=0, then loadb with readnum=1, then loadc with shift=01 and ALUop=00, then write with writenum=2 and vsel=00.
REQ-040 CMP: in=16'hA801 -> loads=1 for exactly one cycle; write=0 and loadc=0 throughout.
REQ-041 Illegal encoding 16'hE000 -> illegal pulses for one cycle, no strobes, back to WAIT; reset asserted during GET_B of ADD -> next cycle WAIT with all strobes 0 and IR=0.
REQ-042 load asserted outside WAIT leaves IR unchanged; s asserted during EXEC does not alter the state sequence.
